// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback register file.
package wb_regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

endpackage

// File: rtl/wb_regfile_wb_select.sv
// Writeback-value select: load data or ALU result.
module wb_select #(
  parameter int DATA_W = 32
) (
  input  logic              memtoreg,
  input  logic [DATA_W-1:0] rd,
  input  logic [DATA_W-1:0] aluresult,
  output logic [DATA_W-1:0] sel
);

  // Pure mux, independent of the write enable so EX forwarding always sees it.
  always_comb begin
    sel = memtoreg ? rd : aluresult;
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file with two combinational read ports and
// a committed-write counter. Register 0 is hard-wired to zero.
// Optional feature macro: WB_REGFILE_BYPASS_EN -- when defined, a read of the
// register being written this cycle returns the incoming writeback value.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_memtoreg,
  input  logic              WB_regwrite,
  input  logic [DATA_W-1:0] WB_rd,
  input  logic [DATA_W-1:0] WB_aluresult,
  input  logic [ADDR_W-1:0] WB_writereg,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       wb_count
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [31:0]       count_q;
  logic              commit;

  wb_select #(.DATA_W(DATA_W)) u_wb_select (
    .memtoreg (WB_memtoreg),
    .rd       (WB_rd),
    .aluresult(WB_aluresult),
    .sel      (wb_data)
  );

  // A write only lands when enabled, not aimed at r0, and not overridden by reset.
  assign commit = WB_regwrite && (WB_writereg != ZERO_IDX) && !rst;

  // Register storage: reset clears everything, otherwise commit one write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[WB_writereg] <= wb_data;
    end
  end

  // Committed-write counter; wraps silently at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (commit) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign wb_count = count_q;

  // Read port rs: r0 reads zero, optional same-cycle write-through.
  always_comb begin
    rs_data = regs_q[rs_addr];
    if (rs_addr == ZERO_IDX) begin
      rs_data = '0;
`ifdef WB_REGFILE_BYPASS_EN
    end else if (commit && (rs_addr == WB_writereg)) begin
      rs_data = wb_data;
`endif
    end
  end

  // Read port rt: same rules as rs, evaluated independently.
  always_comb begin
    rt_data = regs_q[rt_addr];
    if (rt_addr == ZERO_IDX) begin
      rt_data = '0;
`ifdef WB_REGFILE_BYPASS_EN
    end else if (commit && (rt_addr == WB_writereg)) begin
      rt_data = wb_data;
`endif
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, counter wrap,
// and randomized traffic against a behavioural register-file model.
module tb_wb_regfile;

`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        WB_memtoreg;
  logic        WB_regwrite;
  logic [31:0] WB_rd;
  logic [31:0] WB_aluresult;
  logic [4:0]  WB_writereg;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic [31:0] wb_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];
  logic [31:0] mcnt;

  typedef struct {
    logic        rst;
    logic        we;
    logic        m2r;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_wb;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl [13];

  wb_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .WB_memtoreg (WB_memtoreg),
    .WB_regwrite (WB_regwrite),
    .WB_rd       (WB_rd),
    .WB_aluresult(WB_aluresult),
    .WB_writereg (WB_writereg),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .wb_data     (wb_data),
    .wb_count    (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic we, input logic m2r,
                              input logic [31:0] rd, input logic [31:0] alu,
                              input logic [4:0] wr, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [31:0] e_rs,
                              input logic [31:0] e_rt, input logic [31:0] e_wb,
                              input logic [31:0] e_cnt);
    vec_t v;
    v.rst = r; v.we = we; v.m2r = m2r; v.rd = rd; v.alu = alu; v.wr = wr;
    v.rs = rs; v.rt = rt; v.e_rs = e_rs; v.e_rt = e_rt; v.e_wb = e_wb;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: value a read port should present before the coming edge.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] wbv;
    wbv = WB_memtoreg ? WB_rd : WB_aluresult;
    if (a == 5'd0) return 32'd0;
    if (BYP && !rst && WB_regwrite && WB_writereg != 5'd0 && a == WB_writereg)
      return wbv;
    return mregs[a];
  endfunction

  // Reference model: effect of the coming edge.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      mcnt = 32'd0;
    end else if (WB_regwrite && WB_writereg != 5'd0) begin
      mregs[WB_writereg] = WB_memtoreg ? WB_rd : WB_aluresult;
      mcnt = mcnt + 32'd1;
    end
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    rst = v.rst; WB_regwrite = v.we; WB_memtoreg = v.m2r; WB_rd = v.rd;
    WB_aluresult = v.alu; WB_writereg = v.wr; rs_addr = v.rs; rt_addr = v.rt;
    #1;
    check($sformatf("vec%0d rs_data", idx), rs_data, v.e_rs);
    check($sformatf("vec%0d rt_data", idx), rt_data, v.e_rt);
    check($sformatf("vec%0d wb_data", idx), wb_data, v.e_wb);
    check($sformatf("vec%0d wb_count", idx), wb_count, v.e_cnt);
    clock_edge();
  endtask

  initial begin
    rst = 1'b1; WB_regwrite = 1'b0; WB_memtoreg = 1'b0; WB_rd = '0;
    WB_aluresult = '0; WB_writereg = '0; rs_addr = '0; rt_addr = '0;
    mcnt = '0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'hxxxx_xxxx;

    @(negedge clk);
    clock_edge();
    clock_edge();
    rst = 1'b0;

    // All indices read zero after reset, counter cleared.
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      #1;
      check($sformatf("reset rs[%0d]", i), rs_data, 32'd0);
      check($sformatf("reset rt[%0d]", 31 - i), rt_data, 32'd0);
    end
    check("reset wb_count", wb_count, 32'd0);

    tbl[0]  = mk(0, 1, 0, 32'h0, 32'h1234, 5'd5, 5'd5, 5'd0,
                 BYP ? 32'h1234 : 32'h0, 32'h0, 32'h1234, 32'd0);
    tbl[1]  = mk(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7,
                 32'h1234, 32'h0, 32'h0, 32'd1);
    tbl[2]  = mk(0, 1, 1, 32'hDEADBEEF, 32'h1, 5'd7, 5'd7, 5'd5,
                 BYP ? 32'hDEADBEEF : 32'h0, 32'h1234, 32'hDEADBEEF, 32'd1);
    tbl[3]  = mk(0, 1, 0, 32'h0, 32'hFFFF, 5'd0, 5'd0, 5'd7,
                 32'h0, 32'hDEADBEEF, 32'hFFFF, 32'd2);
    tbl[4]  = mk(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0,
                 32'h0, 32'h0, 32'h0, 32'd2);
    tbl[5]  = mk(0, 1, 0, 32'h0, 32'h11, 5'd9, 5'd9, 5'd9,
                 BYP ? 32'h11 : 32'h0, BYP ? 32'h11 : 32'h0, 32'h11, 32'd2);
    tbl[6]  = mk(0, 1, 0, 32'h0, 32'h55, 5'd9, 5'd9, 5'd9,
                 BYP ? 32'h55 : 32'h11, BYP ? 32'h55 : 32'h11, 32'h55, 32'd3);
    tbl[7]  = mk(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9,
                 32'h55, 32'h55, 32'h0, 32'd4);
    tbl[8]  = mk(0, 0, 0, 32'h0, 32'h77, 5'd9, 5'd9, 5'd7,
                 32'h55, 32'hDEADBEEF, 32'h77, 32'd4);
    tbl[9]  = mk(1, 1, 0, 32'h0, 32'hAA, 5'd3, 5'd3, 5'd9,
                 32'h0, 32'h55, 32'hAA, 32'd4);
    tbl[10] = mk(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd9,
                 32'h0, 32'h0, 32'h0, 32'd0);
    tbl[11] = mk(0, 1, 0, 32'h0, 32'hBB, 5'd3, 5'd3, 5'd0,
                 BYP ? 32'hBB : 32'h0, 32'h0, 32'hBB, 32'd0);
    tbl[12] = mk(0, 0, 1, 32'h5, 32'h0, 5'd0, 5'd3, 5'd3,
                 32'hBB, 32'hBB, 32'h5, 32'd1);

    for (int i = 0; i < 13; i++) apply_vec(tbl[i], i);

    // Counter wrap: preload the counter to all-ones, then one valid write.
    rst = 1'b0; WB_regwrite = 1'b0;
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    mcnt = 32'hFFFF_FFFF;
    WB_regwrite = 1'b1; WB_memtoreg = 1'b0; WB_aluresult = 32'hC0DE;
    WB_writereg = 5'd12; rs_addr = 5'd12; rt_addr = 5'd3;
    #1;
    check("wrap preload wb_count", wb_count, 32'hFFFF_FFFF);
    clock_edge();
    WB_regwrite = 1'b0;
    #1;
    check("wrap wb_count", wb_count, 32'd0);
    check("wrap reg12", rs_data, 32'hC0DE);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 39) == 0);
      WB_regwrite  = ($urandom_range(0, 3) != 0);
      WB_memtoreg  = 1'($urandom);
      WB_rd        = $urandom;
      WB_aluresult = $urandom;
      WB_writereg  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      rs_addr      = ($urandom_range(0, 2) == 0) ? WB_writereg : 5'($urandom);
      rt_addr      = ($urandom_range(0, 2) == 0) ? WB_writereg : 5'($urandom);
      #1;
      check("rand rs_data", rs_data, model_read(rs_addr));
      check("rand rt_data", rt_data, model_read(rt_addr));
      check("rand wb_data", wb_data, WB_memtoreg ? WB_rd : WB_aluresult);
      check("rand wb_count", wb_count, mcnt);
      clock_edge();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
